// File: rtl/blinky_sched.sv
// blinky_sched: arbitrates burst-of-N blink requests onto one LED, plays ON/OFF phases, then a gap.
// Build option: define BLINKY_SCHED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module blinky_sched #(
    parameter int clk_freq_hz = 125_000_000,
    parameter int blink_hz    = 2,
    parameter int num_req     = 4,
    parameter int cnt_w       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [num_req-1:0]       req,
    input  logic [num_req*cnt_w-1:0] req_cnt,
    output logic [num_req-1:0]       gnt,
    output logic [num_req-1:0]       done,
    output logic                     busy,
    output logic                     q
);
    localparam int phase_len = clk_freq_hz / (2 * blink_hz);
    localparam int tmr_w     = $clog2(2 * phase_len);
    localparam int idx_w     = $clog2(num_req);

    localparam logic [tmr_w-1:0] phase_last = tmr_w'(phase_len - 1);
    localparam logic [tmr_w-1:0] gap_last   = tmr_w'(2 * phase_len - 1);
    localparam logic [idx_w-1:0] ptr_init   = idx_w'(num_req - 1);

    if (phase_len < 2) begin : g_bad_phase
        $error("blinky_sched: phase length must be at least 2 clock cycles");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state, state_nx;
    logic [tmr_w-1:0]   tmr, tmr_nx;
    logic [cnt_w-1:0]   rem, rem_nx;
    logic [idx_w-1:0]   win, win_nx;
    logic [idx_w-1:0]   ptr, ptr_nx;
    logic [num_req-1:0] gnt_nx, done_nx;
    logic               busy_nx, q_nx;
    logic               pick_vld;
    logic [idx_w-1:0]   pick;

    // Candidates are scanned farthest-first so the nearest pending one is assigned last and wins.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
`ifdef BLINKY_SCHED_PRIO_EN
        for (int i = num_req - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick_vld = 1'b1;
                pick     = idx_w'(i);
            end
        end
`else
        for (int i = num_req; i >= 1; i--) begin
            if (req[(int'(ptr) + i) % num_req]) begin
                pick_vld = 1'b1;
                pick     = idx_w'((int'(ptr) + i) % num_req);
            end
        end
`endif
    end

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case leaves one unassigned (no latches).
        state_nx = state;
        tmr_nx   = tmr;
        rem_nx   = rem;
        win_nx   = win;
        ptr_nx   = ptr;

        case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    win_nx = pick;
                    rem_nx = req_cnt[int'(pick) * cnt_w +: cnt_w];
                    if (rem_nx != '0) begin
                        state_nx = S_ON;
                        tmr_nx   = phase_last;
                    end else begin
                        state_nx = S_GAP;
                        tmr_nx   = gap_last;
                    end
                end
            end
            S_ON, S_OFF, S_GAP: begin
                if (!req[win]) begin
                    // Abort: requester withdrew; no completion pulse, but it still counts as served.
                    state_nx = S_IDLE;
                    ptr_nx   = win;
                end else if (tmr != '0) begin
                    tmr_nx = tmr - tmr_w'(1);
                end else if (state == S_ON) begin
                    state_nx = S_OFF;
                    tmr_nx   = phase_last;
                end else if (state == S_OFF) begin
                    rem_nx = rem - cnt_w'(1);
                    if (rem_nx != '0) begin
                        state_nx = S_ON;
                        tmr_nx   = phase_last;
                    end else begin
                        state_nx = S_GAP;
                        tmr_nx   = gap_last;
                    end
                end else begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                ptr_nx   = win;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase

        // Outputs are decoded from the next state and registered, so q/gnt/done never glitch.
        gnt_nx  = '0;
        done_nx = '0;
        if (state_nx == S_ON || state_nx == S_OFF || state_nx == S_GAP) begin
            gnt_nx = num_req'(1) << win_nx;
        end
        if (state_nx == S_DONE) begin
            done_nx = num_req'(1) << win_nx;
        end
        busy_nx = (state_nx != S_IDLE);
        q_nx    = (state_nx == S_ON);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            tmr   <= '0;
            rem   <= '0;
            win   <= '0;
            ptr   <= ptr_init;
            gnt   <= '0;
            done  <= '0;
            busy  <= 1'b0;
            q     <= 1'b0;
        end else begin
            state <= state_nx;
            tmr   <= tmr_nx;
            rem   <= rem_nx;
            win   <= win_nx;
            ptr   <= ptr_nx;
            gnt   <= gnt_nx;
            done  <= done_nx;
            busy  <= busy_nx;
            q     <= q_nx;
        end
    end

endmodule
